cpu_io_bridge: RTL and testbench

//  Parametrised Z80 I/O bridge: synchronises the asynchronous iorq_n/rd_n/wr_n strobes into clk,

---
 rtl/cpu_io_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_cpu_io_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: Z80 I/O bridge. Synchronises the asynchronous IORQ/RD/WR strobes,
// decodes the port address against NUM_CH base/mask windows, and runs one
// request/ack transaction per bus cycle, with an ack timeout and a sticky error flag.
module cpu_io_bridge #(
  parameter int                  NUM_CH      = 4,
  parameter logic [NUM_CH*8-1:0] CH_BASE     = 32'hA4A0_9C98,
  parameter logic [NUM_CH*8-1:0] CH_MASK     = 32'hFCFC_FCFC,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        bus_a,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        cd_i,
  output logic [7:0]        cd_o,
  output logic              cd_oe,
  output logic              cs_n,
  output logic [NUM_CH-1:0] ch_req,
  output logic              ch_wr,
  output logic [1:0]        ch_addr,
  output logic [7:0]        ch_wdata,
  input  logic [NUM_CH*8-1:0] ch_rdata,
  input  logic [NUM_CH-1:0] ch_ack,
  output logic              err
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_RELEASE
  } state_t;

  // Strobe synchronisers; they reset to the deasserted (high) level.
  logic [SYNC_STAGES-1:0] iorq_sync_reg;
  logic [SYNC_STAGES-1:0] rd_sync_reg;
  logic [SYNC_STAGES-1:0] wr_sync_reg;
  logic                   s_rd;
  logic                   s_wr;

  // Shift the raw strobes through SYNC_STAGES flops each.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iorq_sync_reg <= '1;
      rd_sync_reg   <= '1;
      wr_sync_reg   <= '1;
    end else begin
      iorq_sync_reg <= {iorq_sync_reg[SYNC_STAGES-2:0], iorq_n};
      rd_sync_reg   <= {rd_sync_reg[SYNC_STAGES-2:0], rd_n};
      wr_sync_reg   <= {wr_sync_reg[SYNC_STAGES-2:0], wr_n};
    end
  end

  assign s_rd = ~iorq_sync_reg[SYNC_STAGES-1] & ~rd_sync_reg[SYNC_STAGES-1];
  assign s_wr = ~iorq_sync_reg[SYNC_STAGES-1] & ~wr_sync_reg[SYNC_STAGES-1];

  // FSM state and registered outputs.
  state_t             state_reg, state_next;
  logic [7:0]         addr_reg, addr_next;
  logic [7:0]         data_reg, data_next;
  logic               rd_reg, rd_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [7:0]         cd_o_reg, cd_o_next;
  logic               cd_oe_reg, cd_oe_next;
  logic               cs_n_reg, cs_n_next;
  logic [NUM_CH-1:0]  ch_req_reg, ch_req_next;
  logic               ch_wr_reg, ch_wr_next;
  logic [1:0]         ch_addr_reg, ch_addr_next;
  logic [7:0]         ch_wdata_reg, ch_wdata_next;
  logic               err_reg, err_next;

  // Address decode against the latched port address.
  logic [NUM_CH-1:0]  hit;
  logic               hit_any;
  logic [SEL_W-1:0]   hit_idx;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_decode
      assign hit[gi] = ((addr_reg & CH_MASK[gi*8 +: 8]) ==
                        (CH_BASE[gi*8 +: 8] & CH_MASK[gi*8 +: 8]));
    end
  endgenerate

  // Priority encoder: scanning downward leaves the lowest matching index.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  logic       sel_ack;
  logic [7:0] sel_rdata;

  assign sel_ack   = ch_ack[sel_reg];
  assign sel_rdata = ch_rdata[{sel_reg, 3'b000} +: 8];

  // Next-state and next-output logic; ch_req defaults to 0 so it pulses for one cycle.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    rd_next       = rd_reg;
    sel_next      = sel_reg;
    cnt_next      = cnt_reg;
    cd_o_next     = cd_o_reg;
    cd_oe_next    = cd_oe_reg;
    cs_n_next     = cs_n_reg;
    ch_req_next   = '0;
    ch_wr_next    = ch_wr_reg;
    ch_addr_next  = ch_addr_reg;
    ch_wdata_next = ch_wdata_reg;
    err_next      = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (s_rd ^ s_wr) begin
          addr_next  = bus_a;
          data_next  = cd_i;
          rd_next    = s_rd;
          state_next = S_DECODE;
        end else if (s_rd & s_wr) begin
          state_next = S_RELEASE;
        end
      end

      S_DECODE: begin
        if (hit_any) begin
          cs_n_next              = 1'b0;
          ch_req_next[hit_idx]   = 1'b1;
          sel_next               = hit_idx;
          ch_wr_next             = ~rd_reg;
          ch_addr_next           = addr_reg[1:0];
          ch_wdata_next          = data_reg;
          state_next             = S_REQ;
        end else begin
          state_next = S_RELEASE;
        end
      end

      S_REQ, S_WAIT: begin
        // An ack already present in the REQ cycle completes the access.
        if (sel_ack) begin
          if (rd_reg) cd_o_next = sel_rdata;
          cd_oe_next = rd_reg & s_rd;
          state_next = S_HOLD;
        end else if (state_reg == S_REQ) begin
          cnt_next   = '0;
          state_next = S_WAIT;
        end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_next   = 1'b1;
          if (rd_reg) cd_o_next = 8'hFF;
          cd_oe_next = rd_reg & s_rd;
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_HOLD: begin
        // Drive the pad only while the CPU is still reading.
        cd_oe_next = rd_reg & s_rd;
        if (!s_rd && !s_wr) begin
          cd_oe_next = 1'b0;
          cs_n_next  = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_RELEASE: begin
        if (!s_rd && !s_wr) begin
          cd_oe_next = 1'b0;
          cs_n_next  = 1'b1;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending transaction at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      rd_reg       <= 1'b0;
      sel_reg      <= '0;
      cnt_reg      <= '0;
      cd_o_reg     <= '0;
      cd_oe_reg    <= 1'b0;
      cs_n_reg     <= 1'b1;
      ch_req_reg   <= '0;
      ch_wr_reg    <= 1'b0;
      ch_addr_reg  <= '0;
      ch_wdata_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      rd_reg       <= rd_next;
      sel_reg      <= sel_next;
      cnt_reg      <= cnt_next;
      cd_o_reg     <= cd_o_next;
      cd_oe_reg    <= cd_oe_next;
      cs_n_reg     <= cs_n_next;
      ch_req_reg   <= ch_req_next;
      ch_wr_reg    <= ch_wr_next;
      ch_addr_reg  <= ch_addr_next;
      ch_wdata_reg <= ch_wdata_next;
      err_reg      <= err_next;
    end
  end

  assign cd_o     = cd_o_reg;
  assign cd_oe    = cd_oe_reg;
  assign cs_n     = cs_n_reg;
  assign ch_req   = ch_req_reg;
  assign ch_wr    = ch_wr_reg;
  assign ch_addr  = ch_addr_reg;
  assign ch_wdata = ch_wdata_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb_cpu_io_bridge: directed tests of cpu_io_bridge. Channel map used here:
// ch0 98-9B, ch1 9C-9F, ch2 A0-A3, ch3 90-9F (overlaps ch0 and ch1).
module tb_cpu_io_bridge;

  logic        clk;
  logic        reset_n;
  logic [7:0]  bus_a;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  cd_i;
  logic [7:0]  cd_o;
  logic        cd_oe;
  logic        cs_n;
  logic [3:0]  ch_req;
  logic        ch_wr;
  logic [1:0]  ch_addr;
  logic [7:0]  ch_wdata;
  logic [31:0] ch_rdata;
  logic [3:0]  ch_ack;
  logic        err;

  cpu_io_bridge #(
    .NUM_CH      (4),
    .CH_BASE     (32'h90A0_9C98),
    .CH_MASK     (32'hF0FC_FCFC),
    .SYNC_STAGES (2),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus_a    (bus_a),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .cd_i     (cd_i),
    .cd_o     (cd_o),
    .cd_oe    (cd_oe),
    .cs_n     (cs_n),
    .ch_req   (ch_req),
    .ch_wr    (ch_wr),
    .ch_addr  (ch_addr),
    .ch_wdata (ch_wdata),
    .ch_rdata (ch_rdata),
    .ch_ack   (ch_ack),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral responder: acks resp_ch resp_delay cycles after its request, for one cycle.
  logic       resp_en;
  int         resp_ch;
  int         resp_delay;
  logic [7:0] resp_data;

  initial begin
    ch_ack   = '0;
    ch_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en && ch_req[resp_ch]) begin
        repeat (resp_delay) @(negedge clk);
        ch_ack[resp_ch]            = 1'b1;
        ch_rdata[resp_ch*8 +: 8]   = resp_data;
        @(negedge clk);
        ch_ack   = '0;
        ch_rdata = '0;
      end
    end
  end

  // Observation accumulated over a transaction.
  int         req_pulses;
  logic [3:0] req_or;
  logic       oe_seen;
  logic       csn_low_seen;
  logic [7:0] last_wdata;

  task automatic clr_mon();
    req_pulses   = 0;
    req_or       = '0;
    oe_seen      = 1'b0;
    csn_low_seen = 1'b0;
    last_wdata   = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (ch_req != 4'b0000) begin
      req_pulses++;
      req_or     = req_or | ch_req;
      last_wdata = ch_wdata;
    end
    if (cd_oe) oe_seen = 1'b1;
    if (!cs_n) csn_low_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_start(input logic [7:0] a, input logic [7:0] d, input logic is_rd);
    bus_a  = a;
    cd_i   = d;
    iorq_n = 1'b0;
    if (is_rd) rd_n = 1'b0;
    else       wr_n = 1'b0;
  endtask

  task automatic bus_end();
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    bus_a      = '0;
    cd_i       = '0;
    iorq_n     = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    resp_en    = 1'b0;
    resp_ch    = 0;
    resp_delay = 0;
    resp_data  = '0;
    clr_mon();

    // Reset state
    ticks(3);
    check_val("rst_cd_o", cd_o, 8'h00);
    check_val("rst_cd_oe", cd_oe, 1'b0);
    check_val("rst_cs_n", cs_n, 1'b1);
    check_val("rst_ch_req", ch_req, 4'b0000);
    check_val("rst_ch_wr", ch_wr, 1'b0);
    check_val("rst_ch_addr", ch_addr, 2'd0);
    check_val("rst_ch_wdata", ch_wdata, 8'h00);
    check_val("rst_err", err, 1'b0);
    reset_n = 1'b1;
    ticks(2);

    // Write hit on ch0, ack one cycle after the request
    clr_mon();
    resp_en = 1'b1; resp_ch = 0; resp_delay = 1; resp_data = 8'h00;
    bus_start(8'h99, 8'h5A, 1'b0);
    ticks(3);
    check_val("wr_latency", ch_req, 4'b0000);
    tick();
    check_val("wr_req", ch_req, 4'b0001);
    check_val("wr_ch_wr", ch_wr, 1'b1);
    check_val("wr_addr", ch_addr, 2'd1);
    check_val("wr_wdata", ch_wdata, 8'h5A);
    check_val("wr_cs_n", cs_n, 1'b0);
    tick();
    check_val("wr_req_pulse", ch_req, 4'b0000);
    ticks(5);
    bus_end();
    ticks(2);
    check_val("wr_cs_held", cs_n, 1'b0);
    tick();
    check_val("wr_cs_release", cs_n, 1'b1);
    check_val("wr_pulses", req_pulses, 1);
    check_val("wr_no_oe", oe_seen, 1'b0);
    ticks(2);

    // Read hit on ch1, ack three cycles after the request
    clr_mon();
    resp_ch = 1; resp_delay = 3; resp_data = 8'hC3;
    bus_start(8'h9D, 8'h00, 1'b1);
    ticks(4);
    check_val("rd_req", ch_req, 4'b0010);
    check_val("rd_ch_wr", ch_wr, 1'b0);
    check_val("rd_addr", ch_addr, 2'd1);
    ticks(3);
    check_val("rd_oe_before_ack", cd_oe, 1'b0);
    tick();
    check_val("rd_oe", cd_oe, 1'b1);
    check_val("rd_data", cd_o, 8'hC3);
    ticks(4);
    bus_end();
    ticks(2);
    check_val("rd_oe_tail", cd_oe, 1'b1);
    tick();
    check_val("rd_oe_off", cd_oe, 1'b0);
    check_val("rd_cs_off", cs_n, 1'b1);
    ticks(2);

    // Miss: no channel decodes 0x10
    clr_mon();
    resp_en = 1'b0;
    bus_start(8'h10, 8'h00, 1'b1);
    ticks(8);
    bus_end();
    ticks(4);
    check_val("miss_pulses", req_pulses, 0);
    check_val("miss_oe", oe_seen, 1'b0);
    check_val("miss_cs", csn_low_seen, 1'b0);

    // Timeout: read ch2, never acked
    clr_mon();
    bus_start(8'hA1, 8'h00, 1'b1);
    ticks(4);
    check_val("to_req", ch_req, 4'b0100);
    ticks(16);
    check_val("to_err_early", err, 1'b0);
    check_val("to_oe_early", cd_oe, 1'b0);
    tick();
    check_val("to_err", err, 1'b1);
    check_val("to_data", cd_o, 8'hFF);
    check_val("to_oe", cd_oe, 1'b1);
    ticks(4);
    bus_end();
    ticks(4);
    check_val("to_oe_off", cd_oe, 1'b0);
    check_val("to_err_sticky", err, 1'b1);

    // Overlap priority and long strobe: 0x98 matches ch0 and ch3, ack in REQ cycle
    clr_mon();
    resp_en = 1'b1; resp_ch = 0; resp_delay = 0;
    bus_start(8'h98, 8'h77, 1'b0);
    ticks(50);
    bus_end();
    ticks(4);
    check_val("ovl_pulses", req_pulses, 1);
    check_val("ovl_which", req_or, 4'b0001);
    check_val("ovl_wdata", last_wdata, 8'h77);
    check_val("ovl_err_sticky", err, 1'b1);
    check_val("ovl_cs_off", cs_n, 1'b1);

    // Reset while a read is holding the bus
    clr_mon();
    resp_ch = 1; resp_delay = 0; resp_data = 8'h3C;
    bus_start(8'h9C, 8'h00, 1'b1);
    ticks(5);
    check_val("rr_oe", cd_oe, 1'b1);
    check_val("rr_data", cd_o, 8'h3C);
    #2 reset_n = 1'b0;
    #1;
    check_val("rr_async_oe", cd_oe, 1'b0);
    check_val("rr_async_cs", cs_n, 1'b1);
    check_val("rr_err_clr", err, 1'b0);
    bus_end();
    tick();
    reset_n = 1'b1;
    ticks(2);

    // Write after reset works normally
    clr_mon();
    resp_ch = 0; resp_delay = 1;
    bus_start(8'h9A, 8'hE7, 1'b0);
    ticks(4);
    check_val("pr_req", ch_req, 4'b0001);
    check_val("pr_ch_wr", ch_wr, 1'b1);
    check_val("pr_addr", ch_addr, 2'd2);
    check_val("pr_wdata", ch_wdata, 8'hE7);
    ticks(6);
    bus_end();
    ticks(4);
    check_val("pr_cs_off", cs_n, 1'b1);
    check_val("pr_pulses", req_pulses, 1);
    check_val("pr_err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
